min_os_host: RTL and testbench

Host-side counterpart of MinOS. It terminates the typed-chunk protocol at the far end of the UART link. It decodes incoming "leds" and "display" chunks into mirror registers, and it schedules outgoing "switches" and "buttons" chunks whenever local inputs change. It sits between a `uart_rx_typed_chunker` and a `uart_tx_typed_chunker` instance, and is used for loopback boards and for emulating the remote host in simulation.

---
 rtl/min_os_host.sv | 177 +++++++++++++++++
 tb/tb_min_os_host.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_os_host.sv
// Host-side MinOS endpoint: decodes leds/display chunks into mirrors and
// schedules switches/buttons chunks toward the TX chunker.
module min_os_host #(
  parameter logic [7:0] LEDS_RX_CHUNK_TYPE     = 8'd2,
  parameter logic [7:0] DISPLAY_RX_CHUNK_TYPE  = 8'd6,
  parameter logic [7:0] SWITCHES_TX_CHUNK_TYPE = 8'd4,
  parameter logic [7:0] BUTTONS_TX_CHUNK_TYPE  = 8'd3,
  parameter int RX_CONTENT_BUFFER_BYTE_SIZE  = 3,
  parameter int RX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int TX_CONTENT_BUFFER_BYTE_SIZE  = 5,
  parameter int TX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int DISPLAY_BUFFER_BYTE_SIZE     = 64
) (
  input  logic CLK,
  input  logic reset,
  input  logic [7:0] rx_chunk_type,
  input  logic [RX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] rx_chunk_bytes,
  input  logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0] rx_chunk_byte_size,
  input  logic rx_is_chunk_ready,
  output logic tx_is_chunk_ready,
  output logic [7:0] tx_chunk_type,
  output logic [TX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] tx_chunk_bytes,
  output logic [TX_CONTENT_BUFFER_INDEX_SIZE-1:0] tx_chunk_byte_size,
  input  logic tx_is_chunker_done,
  input  logic [7:0] switches_in,
  input  logic [7:0] button_index_in,
  input  logic button_pressed_in,
  input  logic button_event,
  output logic [7:0] leds_out,
  output logic [DISPLAY_BUFFER_BYTE_SIZE*8-1:0] display_out,
  output logic leds_updated,
  output logic display_updated,
  output logic rx_error,
  output logic button_overrun
);

  localparam int DW = $clog2(DISPLAY_BUFFER_BYTE_SIZE);

  typedef enum logic [3:0] {
    IDLE, SW_CHECK, SW_START, SW_STOP, SW_WAIT,
    BTN_CHECK, BTN_START, BTN_STOP, BTN_WAIT, FINISHED
  } state_t;

  state_t state;

  logic [7:0] rx_idx;
  logic [7:0] rx_val;
  logic       is_leds;
  logic       is_disp;
  logic       size_one;
  logic       size_two;
  logic       idx_ok;
  logic       unused_rx_bits;

  assign rx_idx   = rx_chunk_bytes[7:0];
  assign rx_val   = rx_chunk_bytes[15:8];
  assign is_leds  = rx_chunk_type == LEDS_RX_CHUNK_TYPE;
  assign is_disp  = rx_chunk_type == DISPLAY_RX_CHUNK_TYPE;
  assign size_one =
    rx_chunk_byte_size == RX_CONTENT_BUFFER_INDEX_SIZE'(1);
  assign size_two =
    rx_chunk_byte_size == RX_CONTENT_BUFFER_INDEX_SIZE'(2);
  assign idx_ok   = 32'(rx_idx) < DISPLAY_BUFFER_BYTE_SIZE;
  assign unused_rx_bits =
    ^rx_chunk_bytes[RX_CONTENT_BUFFER_BYTE_SIZE*8-1:16];

  always_ff @(posedge CLK) begin
    if (reset) begin
      leds_out        <= '0;
      display_out     <= '0;
      leds_updated    <= 1'b0;
      display_updated <= 1'b0;
      rx_error        <= 1'b0;
    end else begin
      leds_updated    <= 1'b0;
      display_updated <= 1'b0;
      rx_error        <= 1'b0;
      if (rx_is_chunk_ready) begin
        unique case (1'b1)
          is_leds: begin
            if (size_one) begin
              leds_out     <= rx_idx;
              leds_updated <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end
          is_disp: begin
            if (size_two && idx_ok) begin
              display_out[{rx_idx[DW-1:0], 3'b000} +: 8] <= rx_val;
              display_updated <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [7:0] last_sent_switches;
  logic [7:0] btn_index;
  logic       btn_pressed;
  logic       button_pending;
  logic       sw_pending;

  assign sw_pending = switches_in != last_sent_switches;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state              <= IDLE;
      tx_is_chunk_ready  <= 1'b0;
      tx_chunk_type      <= '0;
      tx_chunk_bytes     <= '0;
      tx_chunk_byte_size <= '0;
      last_sent_switches <= '0;
      btn_index          <= '0;
      btn_pressed        <= 1'b0;
      button_pending     <= 1'b0;
      button_overrun     <= 1'b0;
    end else begin
      button_overrun <= 1'b0;
      case (state)
        IDLE:
          if (sw_pending || button_pending) state <= SW_CHECK;
        SW_CHECK:
          state <= sw_pending ? SW_START : BTN_CHECK;
        SW_START: begin
          tx_chunk_type       <= SWITCHES_TX_CHUNK_TYPE;
          tx_chunk_bytes[7:0] <= switches_in;
          tx_chunk_byte_size  <= TX_CONTENT_BUFFER_INDEX_SIZE'(1);
          tx_is_chunk_ready   <= 1'b1;
          last_sent_switches  <= switches_in;
          state               <= SW_STOP;
        end
        SW_STOP: begin
          tx_is_chunk_ready  <= 1'b0;
          tx_chunk_byte_size <= '0;
          state              <= SW_WAIT;
        end
        SW_WAIT:
          if (tx_is_chunker_done) state <= BTN_CHECK;
        BTN_CHECK:
          state <= button_pending ? BTN_START : FINISHED;
        BTN_START: begin
          tx_chunk_type  <= BUTTONS_TX_CHUNK_TYPE;
          tx_chunk_bytes[15:0] <= {7'b0, btn_pressed, btn_index};
          tx_chunk_byte_size   <= TX_CONTENT_BUFFER_INDEX_SIZE'(2);
          tx_is_chunk_ready    <= 1'b1;
          button_pending       <= 1'b0;
          state                <= BTN_STOP;
        end
        BTN_STOP: begin
          tx_is_chunk_ready  <= 1'b0;
          tx_chunk_byte_size <= '0;
          state              <= BTN_WAIT;
        end
        BTN_WAIT:
          if (tx_is_chunker_done) state <= FINISHED;
        FINISHED:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
      // an event landing on the START load survives the clear above
      if (button_event) begin
        btn_index      <= button_index_in;
        btn_pressed    <= button_pressed_in;
        button_pending <= 1'b1;
        if (button_pending && state != BTN_START)
          button_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_min_os_host.sv
// Bench for min_os_host: RX vector table, randomized RX against a
// mirror model, and hand sequences for the TX scheduler.
module tb_min_os_host;

  logic CLK;
  logic reset;
  logic [7:0] rx_chunk_type;
  logic [23:0] rx_chunk_bytes;
  logic [31:0] rx_chunk_byte_size;
  logic rx_is_chunk_ready;
  logic tx_is_chunk_ready;
  logic [7:0] tx_chunk_type;
  logic [39:0] tx_chunk_bytes;
  logic [31:0] tx_chunk_byte_size;
  logic tx_is_chunker_done;
  logic [7:0] switches_in;
  logic [7:0] button_index_in;
  logic button_pressed_in;
  logic button_event;
  logic [7:0] leds_out;
  logic [511:0] display_out;
  logic leds_updated;
  logic display_updated;
  logic rx_error;
  logic button_overrun;

  min_os_host dut (
    .CLK(CLK),
    .reset(reset),
    .rx_chunk_type(rx_chunk_type),
    .rx_chunk_bytes(rx_chunk_bytes),
    .rx_chunk_byte_size(rx_chunk_byte_size),
    .rx_is_chunk_ready(rx_is_chunk_ready),
    .tx_is_chunk_ready(tx_is_chunk_ready),
    .tx_chunk_type(tx_chunk_type),
    .tx_chunk_bytes(tx_chunk_bytes),
    .tx_chunk_byte_size(tx_chunk_byte_size),
    .tx_is_chunker_done(tx_is_chunker_done),
    .switches_in(switches_in),
    .button_index_in(button_index_in),
    .button_pressed_in(button_pressed_in),
    .button_event(button_event),
    .leds_out(leds_out),
    .display_out(display_out),
    .leds_updated(leds_updated),
    .display_updated(display_updated),
    .rx_error(rx_error),
    .button_overrun(button_overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  leds_m;
  logic [7:0]  dm [64];
  logic [39:0] txb_m;

  typedef struct {
    logic [7:0]  typ;
    logic [23:0] bytes;
    logic [31:0] size;
    logic        rdy;
    logic [7:0]  e_leds;
    logic        e_lu;
    logic        e_du;
    logic        e_err;
    int          didx;
    logic [7:0]  e_dval;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [511:0] act,
                       input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pack_disp();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = dm[i];
    return r;
  endfunction

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!tx_is_chunk_ready && k < 40) begin
      step();
      k++;
    end
    n_cmp++;
    if (!tx_is_chunk_ready) begin
      n_bad++;
      $display("FAIL %s: got no request expected one within 40 cycles",
               name);
    end
  endtask

  task automatic pulse_done();
    tx_is_chunker_done = 1'b1;
    step();
    tx_is_chunker_done = 1'b0;
  endtask

  task automatic no_send(input string name);
    int c;
    c = 0;
    repeat (12) begin
      step();
      if (tx_is_chunk_ready) c++;
    end
    check(name, 512'(c), 512'd0);
  endtask

  task automatic check_sw(input string name, input logic [7:0] sw);
    txb_m[7:0] = sw;
    check({name, "_rdy"}, 512'(tx_is_chunk_ready), 512'd1);
    check({name, "_type"}, 512'(tx_chunk_type), 512'd4);
    check({name, "_bytes"}, 512'(tx_chunk_bytes), 512'(txb_m));
    check({name, "_size"}, 512'(tx_chunk_byte_size), 512'd1);
  endtask

  task automatic check_btn(input string name, input logic [7:0] idx,
                           input logic p);
    txb_m[15:0] = {7'b0, p, idx};
    check({name, "_rdy"}, 512'(tx_is_chunk_ready), 512'd1);
    check({name, "_type"}, 512'(tx_chunk_type), 512'd3);
    check({name, "_bytes"}, 512'(tx_chunk_bytes), 512'(txb_m));
    check({name, "_size"}, 512'(tx_chunk_byte_size), 512'd2);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_rdy"}, 512'(tx_is_chunk_ready), 512'd0);
    check({name, "_type"}, 512'(tx_chunk_type), 512'd0);
    check({name, "_bytes"}, 512'(tx_chunk_bytes), 512'd0);
    check({name, "_size"}, 512'(tx_chunk_byte_size), 512'd0);
    check({name, "_leds"}, 512'(leds_out), 512'd0);
    check({name, "_disp"}, display_out, 512'd0);
    check({name, "_strobes"},
          512'({leds_updated, display_updated, rx_error, button_overrun}),
          512'd0);
  endtask

  initial begin
    logic [7:0]  typ;
    logic [23:0] b;
    logic [31:0] sz;
    logic        rdy;
    logic        elu, edu, eerr;

    tbl[0] = '{8'd2, 24'h0000A5, 32'd1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 63, 8'h00};
    tbl[1] = '{8'd0, 24'h000000, 32'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 63, 8'h00};
    tbl[2] = '{8'd6, 24'h007E3F, 32'd2, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 63, 8'h7E};
    tbl[3] = '{8'd6, 24'h001140, 32'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 63, 8'h7E};
    tbl[4] = '{8'd2, 24'h000011, 32'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 63, 8'h7E};
    tbl[5] = '{8'd9, 24'h000001, 32'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 63, 8'h7E};
    tbl[6] = '{8'd6, 24'h000155, 32'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 8'h00};
    tbl[7] = '{8'd6, 24'h005500, 32'd2, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 0, 8'h55};
    tbl[8] = '{8'd6, 24'h0099FF, 32'd2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 63, 8'h7E};
    tbl[9] = '{8'd2, 24'h00003C, 32'd1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 0, 8'h55};

    reset = 1'b1;
    rx_chunk_type = '0;
    rx_chunk_bytes = '0;
    rx_chunk_byte_size = '0;
    rx_is_chunk_ready = 1'b0;
    tx_is_chunker_done = 1'b0;
    switches_in = '0;
    button_index_in = '0;
    button_pressed_in = 1'b0;
    button_event = 1'b0;
    txb_m = '0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    foreach (tbl[i]) begin
      rx_chunk_type      = tbl[i].typ;
      rx_chunk_bytes     = tbl[i].bytes;
      rx_chunk_byte_size = tbl[i].size;
      rx_is_chunk_ready  = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_leds", i), 512'(leds_out),
            512'(tbl[i].e_leds));
      check($sformatf("tbl%0d_lu", i), 512'(leds_updated),
            512'(tbl[i].e_lu));
      check($sformatf("tbl%0d_du", i), 512'(display_updated),
            512'(tbl[i].e_du));
      check($sformatf("tbl%0d_err", i), 512'(rx_error),
            512'(tbl[i].e_err));
      check($sformatf("tbl%0d_dbyte", i),
            512'(display_out[8*tbl[i].didx +: 8]), 512'(tbl[i].e_dval));
    end
    rx_is_chunk_ready = 1'b0;
    step();
    check("tbl_strobes_clear",
          512'({leds_updated, display_updated, rx_error}), 512'd0);

    leds_m = 8'h3C;
    for (int i = 0; i < 64; i++) dm[i] = 8'h00;
    dm[63] = 8'h7E;
    dm[0]  = 8'h55;
    check("tbl_disp_full", display_out, pack_disp());

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: typ = 8'd2;
        1, 3: typ = 8'd6;
        default: typ = 8'($urandom_range(0, 255));
      endcase
      b = 24'($urandom());
      b[7:0] = 8'($urandom_range(0, 80));
      sz = 32'($urandom_range(0, 3));
      rdy = $urandom_range(0, 3) != 0;
      elu = 1'b0;
      edu = 1'b0;
      eerr = 1'b0;
      if (rdy && typ == 8'd2) begin
        if (sz == 1) begin
          leds_m = b[7:0];
          elu = 1'b1;
        end else eerr = 1'b1;
      end else if (rdy && typ == 8'd6) begin
        if (sz == 2 && b[7:0] < 64) begin
          dm[b[5:0]] = b[15:8];
          edu = 1'b1;
        end else eerr = 1'b1;
      end
      rx_chunk_type      = typ;
      rx_chunk_bytes     = b;
      rx_chunk_byte_size = sz;
      rx_is_chunk_ready  = rdy;
      step();
      check($sformatf("rnd%0d_leds", n), 512'(leds_out), 512'(leds_m));
      check($sformatf("rnd%0d_disp", n), display_out, pack_disp());
      check($sformatf("rnd%0d_strobes", n),
            512'({leds_updated, display_updated, rx_error}),
            512'({elu, edu, eerr}));
      check($sformatf("rnd%0d_txidle", n), 512'(tx_is_chunk_ready),
            512'd0);
    end
    rx_is_chunk_ready = 1'b0;
    step();

    // switches 0 -> 0x0F: request exactly three cycles later
    switches_in = 8'h0F;
    step();
    check("sw_lat1", 512'(tx_is_chunk_ready), 512'd0);
    step();
    check("sw_lat2", 512'(tx_is_chunk_ready), 512'd0);
    step();
    check_sw("sw_lat3", 8'h0F);
    step();
    check("sw_width_rdy", 512'(tx_is_chunk_ready), 512'd0);
    check("sw_width_size", 512'(tx_chunk_byte_size), 512'd0);
    pulse_done();
    no_send("sw_steady");

    // switch change plus button event: switches first, then buttons
    switches_in = 8'h33;
    button_index_in = 8'd5;
    button_pressed_in = 1'b1;
    button_event = 1'b1;
    step();
    button_event = 1'b0;
    wait_ready("both_sw_wait");
    check_sw("both_sw", 8'h33);
    step();
    pulse_done();
    step();
    check("both_gap", 512'(tx_is_chunk_ready), 512'd0);
    step();
    check_btn("both_btn", 8'd5, 1'b1);
    step();
    pulse_done();
    no_send("both_steady");

    // two events during a stalled switches transfer
    switches_in = 8'h44;
    wait_ready("ovr_sw_wait");
    check_sw("ovr_sw", 8'h44);
    step();
    button_index_in = 8'd7;
    button_pressed_in = 1'b0;
    button_event = 1'b1;
    step();
    button_event = 1'b0;
    check("ovr_first", 512'(button_overrun), 512'd0);
    button_index_in = 8'd9;
    button_pressed_in = 1'b1;
    button_event = 1'b1;
    step();
    button_event = 1'b0;
    check("ovr_second", 512'(button_overrun), 512'd1);
    step();
    check("ovr_once", 512'(button_overrun), 512'd0);
    pulse_done();
    wait_ready("ovr_btn_wait");
    check_btn("ovr_btn", 8'd9, 1'b1);
    step();
    pulse_done();
    no_send("ovr_steady");

    // event coinciding with the buttons START load is kept
    switches_in = 8'h21;
    button_index_in = 8'd2;
    button_pressed_in = 1'b1;
    button_event = 1'b1;
    step();
    button_event = 1'b0;
    wait_ready("coin_sw_wait");
    check_sw("coin_sw", 8'h21);
    step();
    pulse_done();
    step();
    button_index_in = 8'd10;
    button_pressed_in = 1'b0;
    button_event = 1'b1;
    step();
    button_event = 1'b0;
    check_btn("coin_a", 8'd2, 1'b1);
    step();
    pulse_done();
    wait_ready("coin_b_wait");
    check_btn("coin_b", 8'd10, 1'b0);
    step();
    pulse_done();
    no_send("coin_steady");

    // reset while waiting for done; late done is ignored
    switches_in = 8'h5A;
    wait_ready("rst_sw_wait");
    check_sw("rst_sw", 8'h5A);
    step();
    reset = 1'b1;
    switches_in = 8'h00;
    step();
    reset = 1'b0;
    txb_m = '0;
    check_reset_state("rst_mid");
    pulse_done();
    no_send("rst_late_done");
    check("rst_late_type", 512'(tx_chunk_type), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
